frv_imem_responder: RTL and testbench

- Responder (memory side) of the core's req/gnt memory bus; the counterpart to the fetch stage's instruction-memory initiator.
- Contains a word-addressed, byte-strobed synchronous SRAM with configurable grant wait states and an out-of-range error response.
- Used as the instruction/data memory in core-level simulation and FPGA builds.
- Response data/error is valid exactly one cycle after the grant cycle, matching the initiator's response-tracking assumption.

---
 rtl/frv_mem_bus_pkg.sv | 29 ++
 rtl/frv_sram_array.sv | 53 +++++
 rtl/frv_imem_responder.sv | 180 ++++++++++++++++++
 tb/tb_frv_imem_responder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// frv_mem_bus_pkg
//   Shared definitions for the core's req/gnt memory bus: data width, the
//   request bundle, and the stall LFSR constants used by responders built with
//   FRV_IMEM_RESPONDER_STALL_RAND_EN.
// -----------------------------------------------------------------------------
package frv_mem_bus_pkg;

    // Architectural data/address width of the bus.
    localparam int XL             = 32;
    localparam int MEM_WORD_BYTES = 4;

    // Request fields the initiator holds stable from req until gnt.
    typedef struct packed {
        logic                      wen;
        logic [MEM_WORD_BYTES-1:0] strb;
        logic [XL-1:0]             wdata;
        logic [XL-1:0]             addr;
    } mem_req_t;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bit positions 7,5,4,3).
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_step(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/frv_sram_array.sv
// -----------------------------------------------------------------------------
// frv_sram_array
//   DEPTH x 32-bit single-port synchronous SRAM with per-byte write enables.
//   Read data appears on o_rdata the cycle after an enabled read and holds
//   until the next one.
//
// Ports:
//   g_clk    in   clock
//   i_en     in   access enable (one access per cycle)
//   i_wen    in   1 = write, 0 = read
//   i_strb   in   byte write strobes, bit i -> bits 8i+7:8i
//   i_idx    in   word index
//   i_wdata  in   write data
//   o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module frv_sram_array
    import frv_mem_bus_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter int    AW        = 10,
    parameter string INIT_FILE = ""
) (
    input  logic                      g_clk,
    input  logic                      i_en,
    input  logic                      i_wen,
    input  logic [MEM_WORD_BYTES-1:0] i_strb,
    input  logic [AW-1:0]             i_idx,
    input  logic [XL-1:0]             i_wdata,
    output logic [XL-1:0]             o_rdata
);

    logic [XL-1:0] r_mem [DEPTH];
    logic [XL-1:0] r_rdata;

    // NOTE: the array and its read register have no reset; a reset would
    // turn the RAM into thousands of flops and stop it mapping to block RAM.
    always_ff @(posedge g_clk) begin
        if (i_en) begin
            if (i_wen) begin
                for (int b = 0; b < MEM_WORD_BYTES; b++) begin
                    if (i_strb[b]) begin
                        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/frv_imem_responder.sv
// -----------------------------------------------------------------------------
// frv_imem_responder
//   Memory-side responder of the core's req/gnt bus. Grants a held request
//   after WAIT_CYCLES cycles, then presents read data or an error flag exactly
//   one cycle after the grant. Addresses outside
//   [BASE_ADDR, BASE_ADDR + 4*DEPTH) get an error response with no SRAM access.
//
//   Build option: FRV_IMEM_RESPONDER_STALL_RAND_EN adds 0..3 pseudo-random
//   extra stall cycles per request from an 8-bit LFSR stepped on each grant.
//
// Ports:
//   g_clk      in   clock
//   g_resetn   in   asynchronous active-low reset
//   mem_req    in   request valid, held with its fields until mem_gnt
//   mem_wen    in   write enable
//   mem_strb   in   byte write strobes
//   mem_wdata  in   write data
//   mem_addr   in   byte address, bits 1:0 ignored
//   mem_gnt    out  request accepted this cycle (combinational from mem_req)
//   mem_error  out  out-of-range flag, valid in the response cycle
//   mem_rdata  out  read data in the response cycle, held otherwise
// -----------------------------------------------------------------------------
module frv_imem_responder
    import frv_mem_bus_pkg::*;
#(
    parameter int unsigned    DEPTH       = 1024,
    parameter logic [XL-1:0]  BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned    WAIT_CYCLES = 0,
    parameter string          INIT_FILE   = ""
) (
    input  logic                      g_clk,
    input  logic                      g_resetn,
    input  logic                      mem_req,
    input  logic                      mem_wen,
    input  logic [MEM_WORD_BYTES-1:0] mem_strb,
    input  logic [XL-1:0]             mem_wdata,
    input  logic [XL-1:0]             mem_addr,
    output logic                      mem_gnt,
    output logic                      mem_error,
    output logic [XL-1:0]             mem_rdata
);

    localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         WORD_SH   = $clog2(MEM_WORD_BYTES);
    // Wide enough for 15 base cycles plus 3 random extra.
    localparam logic [4:0] WAIT_BASE = 5'(WAIT_CYCLES);

    mem_req_t      w_req;
    logic          r_rst_done;
    logic [4:0]    r_wait_cnt;
    logic [4:0]    w_wait_target;
    logic          w_gnt;
    logic [XL-1:0] w_offset;
    logic [XL-1:0] w_word;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic          w_sram_en;
    logic [XL-1:0] w_sram_rdata;
    logic          r_rsp_valid;
    logic          r_rsp_rd;
    logic          r_rsp_err;
    logic [XL-1:0] r_rdata_hold;
    logic [XL-1:0] w_rdata;

    assign w_req = '{wen: mem_wen, strb: mem_strb, wdata: mem_wdata, addr: mem_addr};

    // Unsigned wrap: addresses below BASE_ADDR become huge offsets and fail
    // the range check the same way as addresses past the top.
    assign w_offset   = w_req.addr - BASE_ADDR;
    assign w_word     = w_offset >> WORD_SH;
    assign w_in_range = (w_word < DEPTH);
    assign w_idx      = w_word[AW-1:0];

    assign w_gnt = mem_req && r_rst_done && (r_wait_cnt == w_wait_target);

    // -------------------------------------------------------------------------
    // Wait-state target
    // -------------------------------------------------------------------------
`ifdef FRV_IMEM_RESPONDER_STALL_RAND_EN
    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_next;
    logic [4:0] r_wait_target;

    assign w_lfsr_next = lfsr_step(r_lfsr);

    // The target only changes while the counter is clearing, so a request in
    // progress always sees a stable comparison value.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_lfsr        <= LFSR_SEED;
            r_wait_target <= WAIT_BASE + 5'(LFSR_SEED[1:0]);
        end else if (w_gnt) begin
            r_lfsr        <= w_lfsr_next;
            r_wait_target <= WAIT_BASE + 5'(w_lfsr_next[1:0]);
        end else if (!mem_req) begin
            r_wait_target <= WAIT_BASE + 5'(r_lfsr[1:0]);
        end
    end

    assign w_wait_target = r_wait_target;
`else
    assign w_wait_target = WAIT_BASE;
`endif

    // -------------------------------------------------------------------------
    // Reset-release flag and wait counter
    // -------------------------------------------------------------------------
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_rst_done <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_rst_done <= 1'b1;
            // A request dropped before grant is discarded along with its count.
            // Counting only starts once grants are possible, so a request held
            // through reset release still sees the full wait.
            if (w_gnt || !mem_req) begin
                r_wait_cnt <= '0;
            end else if (r_rst_done) begin
                r_wait_cnt <= r_wait_cnt + 5'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    assign w_sram_en = w_gnt && w_in_range;

    frv_sram_array #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .g_clk   (g_clk),
        .i_en    (w_sram_en),
        .i_wen   (w_req.wen),
        .i_strb  (w_req.strb),
        .i_idx   (w_idx),
        .i_wdata (w_req.wdata),
        .o_rdata (w_sram_rdata)
    );

    // -------------------------------------------------------------------------
    // Response: exactly one cycle after every grant
    // -------------------------------------------------------------------------
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_rd     <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_rsp_valid <= w_gnt;
            r_rsp_rd    <= w_gnt && w_in_range && !w_req.wen;
            r_rsp_err   <= w_gnt && !w_in_range;
            if (r_rsp_valid) begin
                r_rdata_hold <= w_rdata;
            end
        end
    end

    // Read responses forward the SRAM output; write and error responses drive
    // zero; between responses the last driven value is held.
    // NOTE: the default comes first so every path assigns w_rdata and no
    // latch is inferred.
    always_comb begin
        w_rdata = r_rdata_hold;
        if (r_rsp_valid) begin
            w_rdata = r_rsp_rd ? w_sram_rdata : '0;
        end
    end

    assign mem_gnt   = w_gnt;
    assign mem_error = r_rsp_valid && r_rsp_err;
    assign mem_rdata = w_rdata;

endmodule

// File: tb/tb_frv_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_frv_imem_responder
//   Two responders share clock and reset: dut0 with WAIT_CYCLES=0, dut1 with
//   WAIT_CYCLES=3. A driver issues requests and, on each grant, pushes the
//   response predicted by a word-array memory model into that DUT's queue;
//   a negedge monitor pops and compares in the cycle after every grant and
//   checks error=0 / held rdata in all other cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frv_imem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req   [2];
    logic        wen   [2];
    logic [3:0]  strb  [2];
    logic [31:0] wdata [2];
    logic [31:0] addr  [2];
    logic        gnt   [2];
    logic        err   [2];
    logic [31:0] rdata [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    frv_imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
        .g_clk(clk), .g_resetn(rst_n), .mem_req(req[0]), .mem_wen(wen[0]),
        .mem_strb(strb[0]), .mem_wdata(wdata[0]), .mem_addr(addr[0]),
        .mem_gnt(gnt[0]), .mem_error(err[0]), .mem_rdata(rdata[0])
    );

    frv_imem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut1 (
        .g_clk(clk), .g_resetn(rst_n), .mem_req(req[1]), .mem_wen(wen[1]),
        .mem_strb(strb[1]), .mem_wdata(wdata[1]), .mem_addr(addr[1]),
        .mem_gnt(gnt[1]), .mem_error(err[1]), .mem_rdata(rdata[1])
    );

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h at %0t",
                      name, d, act, exp, $time);
    endtask

    function automatic int unsigned wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // ---------------------------------------------------------------- model
    // Memory contents keyed by (dut, word index); never-written words read 0.
    logic [31:0] model_mem [int unsigned];
    logic [32:0] exp_q0 [$];
    logic [32:0] exp_q1 [$];

    // Returns {error, rdata} for one granted access and applies any write.
    task automatic model_access(input int d, input logic we, input logic [3:0] st,
                                input logic [31:0] wd, input logic [31:0] a,
                                output logic [32:0] rsp);
        logic [31:0] diff;
        int unsigned word;
        int unsigned key;
        logic [31:0] cur;
        diff = a - BASE;
        word = diff / 4;
        key  = d * DEPTH + word;
        if (word >= DEPTH) begin
            rsp = {1'b1, 32'h0};
        end else begin
            cur = model_mem.exists(key) ? model_mem[key] : 32'h0;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) cur[8*b +: 8] = wd[8*b +: 8];
                model_mem[key] = cur;
                rsp = {1'b0, 32'h0};
            end else begin
                rsp = {1'b0, cur};
            end
        end
    endtask

    // ---------------------------------------------------------------- driver
    // Called just after a posedge; returns just after the posedge that ends
    // the grant cycle, with req dropped (a following call re-raises it in the
    // same time step, giving back-to-back requests).
    task automatic issue(input int d, input logic we, input logic [3:0] st,
                         input logic [31:0] wd, input logic [31:0] a);
        int          lat;
        bit          got;
        logic [32:0] rsp;
        req[d] = 1'b1; wen[d] = we; strb[d] = st; wdata[d] = wd; addr[d] = a;
        lat = 0;
        got = 1'b0;
        while (!got && lat <= 40) begin
            @(negedge clk);
            if (gnt[d]) got = 1'b1;
            else lat++;
        end
        if (!got) begin
            check("gnt_seen", d, 32'(got), 32'd1);
        end else begin
`ifdef FRV_IMEM_RESPONDER_STALL_RAND_EN
            check("gnt_latency_window", d,
                  32'(lat >= int'(wait_of(d)) && lat <= int'(wait_of(d)) + 3), 32'd1);
`else
            check("gnt_latency", d, 32'(lat), 32'(wait_of(d)));
`endif
            model_access(d, we, st, wd, a, rsp);
            if (d == 0) exp_q0.push_back(rsp);
            else        exp_q1.push_back(rsp);
        end
        @(posedge clk);
        #1;
        req[d] = 1'b0;
    endtask

    // --------------------------------------------------------------- monitor
    bit          pending [2];
    logic [31:0] last_rd [2];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                check("reset_gnt", d, 32'(gnt[d]), 32'd0);
                check("reset_error", d, 32'(err[d]), 32'd0);
                check("reset_rdata", d, rdata[d], 32'd0);
                pending[d] <= 1'b0;
                last_rd[d] <= 32'd0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (pending[d]) begin
                    int          n;
                    logic [32:0] e;
                    n = (d == 0) ? exp_q0.size() : exp_q1.size();
                    if (n == 0) begin
                        check("rsp_expected", d, 32'(n), 32'd1);
                    end else begin
                        if (d == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        check("rsp_error", d, 32'(err[d]), 32'(e[32]));
                        check("rsp_rdata", d, rdata[d], e[31:0]);
                        last_rd[d] <= e[31:0];
                    end
                end else begin
                    check("idle_error", d, 32'(err[d]), 32'd0);
                    check("idle_rdata_hold", d, rdata[d], last_rd[d]);
                end
                pending[d] <= gnt[d];
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        longint      t0;
        int          sel;
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wen[d] = 1'b0; strb[d] = 4'h0; wdata[d] = 32'h0; addr[d] = BASE;
        end
        #1 rst_n = 1'b0;

        // Request held through reset release: no grant in the first cycle,
        // grant in the second (latency 0 from the next posedge).
        req[0] = 1'b1; wen[0] = 1'b1; strb[0] = 4'hF; wdata[0] = 32'h1234_5678; addr[0] = BASE;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("gnt_first_cycle", 0, 32'(gnt[0]), 32'd0);
        @(posedge clk); #1;
        issue(0, 1'b1, 4'hF, 32'h1234_5678, BASE);

        // Full write then read; partial write then read.
        issue(0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h8000_0010);
        issue(0, 1'b0, 4'b0000, 32'h0,         32'h8000_0010);
        issue(0, 1'b1, 4'b0010, 32'h0000_5500, 32'h8000_0010);
        issue(0, 1'b0, 4'b0000, 32'h0,         32'h8000_0010);
        // Zero-strobe write leaves data intact.
        issue(0, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h8000_0010);
        issue(0, 1'b0, 4'b0000, 32'h0,         32'h8000_0013);

        // Out-of-range on both sides; an out-of-range write must not alias word 0.
        issue(0, 1'b0, 4'b0000, 32'h0,         32'h7FFF_FFFC);
        issue(0, 1'b0, 4'b0000, 32'h0,         BASE + 4 * DEPTH);
        issue(0, 1'b1, 4'b1111, 32'hFFFF_FFFF, 32'h7FFF_FFFC);
        issue(0, 1'b0, 4'b0000, 32'h0,         BASE);

        // WAIT_CYCLES=3: each request granted 3 cycles after it appears.
        issue(1, 1'b1, 4'hF, 32'hCAFE_0020, BASE + 32'h20);
        issue(1, 1'b1, 4'hF, 32'hCAFE_0024, BASE + 32'h24);
`ifndef FRV_IMEM_RESPONDER_STALL_RAND_EN
        t0 = $time;
`endif
        issue(1, 1'b0, 4'h0,    32'h0,         BASE + 32'h20);
        issue(1, 1'b0, 4'h0,    32'h0,         BASE + 32'h24);
        issue(1, 1'b1, 4'b1100, 32'hA5A5_0000, BASE + 32'h20);
        issue(1, 1'b0, 4'h0,    32'h0,         BASE + 32'h20);
`ifndef FRV_IMEM_RESPONDER_STALL_RAND_EN
        check("b2b_four_cycles", 1, 32'(($time - t0) / 10), 32'd16);
`endif

        // Reset in the response cycle of a non-zero read: outputs clear at once
        // and nothing stale appears afterwards.
        issue(0, 1'b0, 4'h0, 32'h0, 32'h8000_0010);
        rst_n = 1'b0;
        #1;
        check("reset_mid_error", 0, 32'(err[0]), 32'd0);
        check("reset_mid_rdata", 0, rdata[0], 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;

        // Randomised traffic over a small prewritten window plus strays.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++)
                issue(d, 1'b1, 4'hF, $urandom, BASE + 32'(4 * w));
            for (int n = 0; n < 120; n++) begin
                sel = $urandom_range(9, 0);
                if (sel < 8)       a = BASE + 32'(4 * $urandom_range(15, 0)) + 32'($urandom_range(3, 0));
                else if (sel == 8) a = BASE - 32'(4 * $urandom_range(4, 1));
                else               a = BASE + 4 * DEPTH + 32'(4 * $urandom_range(3, 0));
                issue(d, 1'($urandom_range(1, 0)), 4'($urandom), $urandom, a);
                repeat ($urandom_range(2, 0)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 0, 32'(exp_q0.size()), 32'd0);
        check("queue_drained", 1, 32'(exp_q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
